// File: rtl/priority_encoder_16_4.sv
// priority_encoder_16_4: sticky 16-line request latch draining highest index first over valid/ready
module priority_encoder_16_4 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d,
  input  logic        en,
  input  logic        ready,
  output logic [3:0]  y,
  output logic        valid,
  output logic [15:0] pend
);
  logic [15:0] clr;
  logic [15:0] pend_next;
  logic [3:0]  idx;
  logic        load;
  assign clr       = (valid & ready) ? (16'b1 << y) : 16'b0;
  assign pend_next = (pend & ~clr) | (en ? d : 16'b0);
  // A presented index is held until accepted, so new requests never preempt it
  assign load      = ~valid | ready;
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < 16; i++) idx = pend_next[i] ? 4'(i) : idx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 16'b0;
      y     <= 4'd0;
      valid <= 1'b0;
    end else begin
      pend <= pend_next;
      if (load) begin
        y     <= idx;
        valid <= |pend_next;
      end
    end
  end
endmodule

// File: tb/tb_priority_encoder_16_4.sv
// tb_priority_encoder_16_4: directed checks of capture, priority drain, backpressure and reset
module tb_priority_encoder_16_4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] d = 16'h0;
  logic        en = 1'b0;
  logic        ready = 1'b0;
  logic [3:0]  y;
  logic        valid;
  logic [15:0] pend;
  int checks = 0;
  int errors = 0;

  priority_encoder_16_4 dut (
    .clk(clk), .rst(rst), .d(d), .en(en), .ready(ready),
    .y(y), .valid(valid), .pend(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] ey, input logic ev, input logic [15:0] ep);
    chk({tag, ".y"}, {12'h0, y}, {12'h0, ey});
    chk({tag, ".valid"}, {15'h0, valid}, {15'h0, ev});
    chk({tag, ".pend"}, pend, ep);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick; tick;
    expect_out("reset", 4'd0, 1'b0, 16'h0000);
    rst = 1'b0;
    // single request
    d = 16'h0020; en = 1'b1; ready = 1'b1;
    tick; expect_out("single_cap", 4'd5, 1'b1, 16'h0020);
    d = 16'h0; en = 1'b0;
    tick; expect_out("single_done", 4'd0, 1'b0, 16'h0000);
    // priority drain
    d = 16'h8421; en = 1'b1;
    tick; expect_out("drain15", 4'd15, 1'b1, 16'h8421);
    d = 16'h0; en = 1'b0;
    tick; expect_out("drain10", 4'd10, 1'b1, 16'h0421);
    tick; expect_out("drain5", 4'd5, 1'b1, 16'h0021);
    tick; expect_out("drain0", 4'd0, 1'b1, 16'h0001);
    tick; expect_out("drain_end", 4'd0, 1'b0, 16'h0000);
    // backpressure, no preemption
    ready = 1'b0; d = 16'h0008; en = 1'b1;
    tick; expect_out("bp_cap", 4'd3, 1'b1, 16'h0008);
    d = 16'h4000;
    tick; expect_out("bp_hold", 4'd3, 1'b1, 16'h4008);
    d = 16'h0; en = 1'b0;
    tick; expect_out("bp_still", 4'd3, 1'b1, 16'h4008);
    ready = 1'b1;
    tick; expect_out("bp_next", 4'd14, 1'b1, 16'h4000);
    tick; expect_out("bp_end", 4'd0, 1'b0, 16'h0000);
    // set wins over clear
    d = 16'h0100; en = 1'b1;
    tick; expect_out("soc1", 4'd8, 1'b1, 16'h0100);
    tick; expect_out("soc2", 4'd8, 1'b1, 16'h0100);
    tick; expect_out("soc3", 4'd8, 1'b1, 16'h0100);
    d = 16'h0; en = 1'b0;
    tick; expect_out("soc_end", 4'd0, 1'b0, 16'h0000);
    // enable gating
    d = 16'hFFFF; en = 1'b0;
    tick; expect_out("gate_idle", 4'd0, 1'b0, 16'h0000);
    ready = 1'b0; d = 16'h0003; en = 1'b1;
    tick; expect_out("gate_load", 4'd1, 1'b1, 16'h0003);
    d = 16'hFFFF; en = 1'b0;
    tick; expect_out("gate_hold", 4'd1, 1'b1, 16'h0003);
    ready = 1'b1;
    tick; expect_out("gate_y0", 4'd0, 1'b1, 16'h0001);
    tick; expect_out("gate_end", 4'd0, 1'b0, 16'h0000);
    // asynchronous reset mid-stream
    ready = 1'b0; d = 16'hFFFF; en = 1'b1;
    tick; expect_out("rst_pre", 4'd15, 1'b1, 16'hFFFF);
    #2 rst = 1'b1;
    #1 expect_out("rst_async", 4'd0, 1'b0, 16'h0000);
    tick; expect_out("rst_held", 4'd0, 1'b0, 16'h0000);
    rst = 1'b0;
    tick; expect_out("rst_recap", 4'd15, 1'b1, 16'hFFFF);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
